instr_encoder: RTL and testbench
================================

# instr_encoder

Buffered MIPS instruction encoder: turns operation requests (op class plus register/immediate/target fields) into 32-bit instruction words for the single-cycle core's supported subset. It is the inverse of the core's opcode/funct control decoder. It sits between a test-program sequencer and the instruction-memory loader. Each word is tagged with its load address, and accepted requests are buffered in a small FIFO with valid/ready on both sides.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- PC_BASE, 32'h0000_3000: address tagged on the first word after reset/flush
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of FIFO and address counter
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid & in_ready at rising edge
- in_op  input  4  0 nop, 1 add, 2 sub, 3 jr, 4 ori, 5 lw, 6 sw, 7 beq, 8 lui, 9 jal, 10–15 illegal
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_imm  input  16  immediate / offset
- in_target  input  26  jal target field
- out_valid  output  1  head entry present
- out_ready  input  1  head consumed when out_valid & out_ready at rising edge
- out_instr  output  32  encoded word at head
- out_pc  output  32  load address of head word
- err  output  1  sticky illegal-op flag (configuration-dependent)

## Operation
- Encoding, fields {31:26,25:21,20:16,15:11,10:6,5:0}:
  - nop: 32'h0
  - add: {000000, rs, rt, rd, 00000, 100000}
  - sub: {000000, rs, rt, rd, 00000, 100010}
  - jr: {000000, rs, 15'b0, 001000}
  - ori: {001101, rs, rt, imm}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - lui: {001111, 00000, rt, imm}
  - jal: {000011, target}
- Fields that are unused by an op are forced to zero, whatever the input.
- Address counter `pc`:
  - Each enqueued word stores the current pc, then pc += 4.
  - pc wraps modulo 2^32.
- FIFO:
  - Circular buffer of DEPTH entries {instr, pc}.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy count is log2(DEPTH)+1 bits.
- in_ready = (count != DEPTH). It is not combinationally dependent on out_ready.
- out_valid = (count != 0). out_instr/out_pc come straight from the head entry, with no combinational path from in_*.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- flush:
  - Pointers and count go to 0, pc goes to PC_BASE.
  - flush dominates a push or pop in the same cycle; that request is dropped.
  - err is unaffected.
- reset (asserted low):
  - Immediately clears pointers and count.
  - pc = PC_BASE, err = 0, so out_valid = 0 and in_ready = 1.
  - FIFO data contents are don't-care.
  - Asserting reset mid-stream discards all buffered words.

## Timing
- Latency: a request accepted at edge N is visible on out_* after edge N (one cycle), provided the FIFO was empty.
- Throughput: one word per cycle in each direction.
- No bypass when full: a request must wait one cycle after a pop frees a slot.
- Output hold rule: out_instr/out_pc remain stable while out_valid & !out_ready.
- Reset values of outputs: in_ready = 1, out_valid = 0, err = 0. out_instr and out_pc show an unspecified head entry and are valid only when out_valid is high.

## Configuration
- INSTR_ENC_ILLEGAL_TRAP_EN defined:
  - Accepted requests with in_op 10–15 are consumed (in_ready behaviour unchanged) but not enqueued, and pc does not advance.
  - err sets on the next edge and stays set until reset.
- Not defined:
  - Illegal ops are encoded as nop (32'h0), enqueued normally, and pc advances.
  - err is tied to 0.

## Test plan
- After reset, push add rs=1 rt=2 rd=3 → next cycle out_valid = 1, out_instr = 0x00221820, out_pc = 0x00003000.
- Push ori rs=0 rt=1 imm=0x1234, then lw rs=1 rt=2 imm=4, then lui rt=5 imm=0xABCD with out_ready = 1 → 0x34011234 @3000, 0x8C220004 @3004, 0x3C05ABCD @3008 in consecutive cycles.
- Hold out_ready = 0 and push DEPTH words, beq rs=1 rt=2 imm=0xFFFF first → in_ready drops after the 4th push and the head stays 0x1022FFFF. One pop, then in_ready = 1 the following cycle.
- jal target 0xC03 with rs/rt/rd/imm all-ones → 0x0C000C03; jr rs=31 with rt=rd=7 → 0x03E00008.
- Flush together with a push while 3 words are queued → out_valid = 0 next cycle; the next push is tagged 0x00003000.
- in_op = 12 → with the macro: err = 1 and nothing enqueued; without it: 0x00000000 enqueued and pc advances by 4.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes op requests into MIPS instruction words for the
// single-cycle core subset and tags each word with its load address. Words
// are queued in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// Optional feature macro: INSTR_ENC_ILLEGAL_TRAP_EN. When it is defined,
// illegal ops are dropped and a sticky err flag is raised. When it is not
// defined, illegal ops are encoded as nop and err is tied low.
module instr_encoder #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_JR  = 4'd3,
    OP_ORI = 4'd4,
    OP_LW  = 4'd5,
    OP_SW  = 4'd6,
    OP_BEQ = 4'd7,
    OP_LUI = 4'd8,
    OP_JAL = 4'd9
  } op_e;

  logic [31:0] enc_instr;
  logic        accept;
  logic        push;
  logic        pop;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  // Encode the request; fields an op does not use stay zero.
  always_comb begin
    enc_instr = '0;
    case (in_op)
      OP_NOP: enc_instr = '0;
      OP_ADD: enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
      OP_SUB: enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
      OP_JR:  enc_instr = {6'b000000, in_rs, 15'b0, 6'b001000};
      OP_ORI: enc_instr = {6'b001101, in_rs, in_rt, in_imm};
      OP_LW:  enc_instr = {6'b100011, in_rs, in_rt, in_imm};
      OP_SW:  enc_instr = {6'b101011, in_rs, in_rt, in_imm};
      OP_BEQ: enc_instr = {6'b000100, in_rs, in_rt, in_imm};
      OP_LUI: enc_instr = {6'b001111, 5'b00000, in_rt, in_imm};
      OP_JAL: enc_instr = {6'b000011, in_target};
      default: enc_instr = '0;
    endcase
  end

  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  logic illegal_op;

  assign illegal_op = (in_op > 4'd9);
  assign push       = accept & ~illegal_op & ~flush;

  // Sticky trap flag: only reset clears it, flush leaves it alone. An illegal
  // request coinciding with flush is dropped like any other request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (accept && illegal_op && !flush) begin
      err <= 1'b1;
    end
  end
`else
  assign push = accept & ~flush;
  assign err  = 1'b0;
`endif

  // Storage array; contents need no reset since only occupied slots are read.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= enc_instr;
      pc_mem[wr_ptr]    <= pc;
    end
  end

  // Pointers, occupancy and address counter; flush overrides push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc     <= PC_BASE;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc     <= PC_BASE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc     <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven encodings checked
// through a scoreboard of {instr, pc}, plus directed full/flush/illegal/reset
// sequences.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        err;

  instr_encoder #(.DEPTH(4), .PC_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_instr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_pc = BASE;
  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Output monitor: a word leaving the FIFO must match the scoreboard head.
  always @(negedge clk) begin
    if (reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_instr, 32'hxxxxxxxx);
      end else begin
        check("out_instr", out_instr, sb[0].instr);
        check("out_pc", out_pc, sb[0].pc);
        void'(sb.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_req(input vec_t v, input bit enq);
    int waited;
    in_valid = 1'b1;
    in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_imm = v.imm; in_target = v.target;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
    end else if (enq) begin
      sb.push_back('{instr: v.exp_instr, pc: model_pc});
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    sb.delete();
    model_pc = BASE;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    out_ready = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [15:0] imm, input logic [25:0] tg,
                              input logic [31:0] e);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.target = tg;
    v.exp_instr = e;
    return v;
  endfunction

  initial begin
    vec_t v;
    vecs[0] = mk(4'd4, 5'd0,  5'd1,  5'd0,  16'h1234, 26'h0, 32'h3401_1234);
    vecs[1] = mk(4'd5, 5'd1,  5'd2,  5'd0,  16'h0004, 26'h0, 32'h8C22_0004);
    vecs[2] = mk(4'd8, 5'd3,  5'd5,  5'd9,  16'hABCD, 26'h3FFFFFF, 32'h3C05_ABCD);
    vecs[3] = mk(4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000C03, 32'h0C00_0C03);
    vecs[4] = mk(4'd3, 5'd31, 5'd7,  5'd7,  16'hFFFF, 26'h3FFFFFF, 32'h03E0_0008);
    vecs[5] = mk(4'd2, 5'd4,  5'd5,  5'd6,  16'hFFFF, 26'h3FFFFFF, 32'h0085_3022);
    vecs[6] = mk(4'd6, 5'd29, 5'd8,  5'd31, 16'hFFFC, 26'h3FFFFFF, 32'hAFA8_FFFC);
    vecs[7] = mk(4'd7, 5'd1,  5'd2,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h1022_FFFF);
    vecs[8] = mk(4'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0000_0000);
    vecs[9] = mk(4'd1, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h03FF_F820);

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // First word latency
    push_req(mk(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820), 1'b1);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_instr", out_instr, 32'h0022_1820);
    check("lat_pc", out_pc, BASE);
    do_flush();
    check("flush_empty", 32'(out_valid), 32'd0);

    // Table at full throughput, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_req(vecs[i], 1'b1);
    drain();

    // Fill to DEPTH with consumer stalled
    out_ready = 1'b0;
    push_req(vecs[7], 1'b1);
    for (int i = 0; i < 3; i++) push_req(vecs[i], 1'b1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_instr, 32'h1022_FFFF);
    @(posedge clk); #1;
    check("hold_head", out_instr, 32'h1022_FFFF);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("pop_in_ready", 32'(in_ready), 32'd1);
    check("pop_head", out_instr, 32'h3401_1234);
    drain();

    // Flush with concurrent push while three words are queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_req(vecs[i], 1'b1);
    in_valid = 1'b1; in_op = 4'd1;
    do_flush();
    check("flush_push_valid", 32'(out_valid), 32'd0);
    check("flush_push_ready", 32'(in_ready), 32'd1);
    push_req(mk(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820), 1'b1);
    check("post_flush_pc", out_pc, BASE);
    drain();

    // Illegal op
    out_ready = 1'b0;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    push_req(mk(4'd12, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0), 1'b0);
    check("ill_not_enq", 32'(out_valid), 32'd0);
    check("ill_err", 32'(err), 32'd1);
`else
    push_req(mk(4'd12, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0), 1'b1);
    check("ill_enq", 32'(out_valid), 32'd1);
    check("ill_instr", out_instr, 32'h0);
    check("ill_err", 32'(err), 32'd0);
`endif
    push_req(vecs[0], 1'b1);
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push_req(vecs[1], 1'b1);
    push_req(vecs[2], 1'b1);
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_err", 32'(err), 32'd0);
    sb.delete();
    model_pc = BASE;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    v = vecs[2];
    push_req(v, 1'b1);
    check("arst_pc", out_pc, BASE);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 32'd1, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
